control_mc: RTL and testbench
=============================

CONTROL_MC -- requirements
Module: control_mc

Interface
REQ-001 SHALL have parameter TMO_W, default 4: width of the memory wait counter; a timeout fires after 2^TMO_W-1 cycles without mem_ack.
REQ-002 SHALL have parameter FAULT_ON_UNDEF, default 1: 1 sends undefined opcodes to FAULT, 0 executes them as NOP.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port opcode, input, 4: instruction opcode from the instruction register, sampled in DECODE.
REQ-006 SHALL have port ctl_adata_zero, input, 1: 1 when adata==0, sampled in EXEC.
REQ-007 SHALL have port mem_ack, input, 1: memory transfer complete; ignored outside FETCH and MEM.
REQ-008 SHALL have port mem_req, output, 1: memory access request.
REQ-009 SHALL have port mem_ifetch, output, 1: 1 means the address is pc (instruction fetch); 0 means the address is the ALU result.
REQ-010 SHALL have ports ir_we and pc_we, output, 1 each: instruction register write strobe and pc update strobe.
REQ-011 SHALL have ports ctl_alu_pc, ctl_alu_imm, ctl_alu_altdest, ctl_wdata_ram, ctl_branch_ind, ctl_branch_taken, ctl_regs_we and ctl_ram_we, output, 1 each: datapath controls with the existing single-cycle meanings.
REQ-012 SHALL have ports fault, output, 1 (sticky fault) and state, output, 3 (current state encoding).

Function
REQ-013 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and FAULT=7; encodings 5 and 6 SHALL go to FAULT on the next cycle.
REQ-014 FETCH: SHALL drive mem_req=1 and mem_ifetch=1; on mem_ack SHALL pulse ir_we the same cycle and go to DECODE.
REQ-015 DECODE: SHALL latch a 7-bit control word {alu_pc, alu_imm, regs_we, ram_we, altdest, branch_op, wdata_ram} from opcode.
REQ-016 The decode table SHALL be:
- 0 = 0010000, 1 = 0110100, 2 = 0110101, 3 = 0101000
- 4 and 5 = 1010110, 6 and 7 = 1010010
- 14 = 1100000 (NOP)
- all other opcodes are undefined.
REQ-017 Undefined opcode: go to FAULT if FAULT_ON_UNDEF=1; otherwise load the word 0000000 and continue.
REQ-018 EXEC: SHALL last exactly one cycle; SHALL register taken = branch_op & (ctl_adata_zero != opcode[0]); next state is MEM for opcodes 2 and 3, WB otherwise.
REQ-019 MEM: SHALL drive mem_req=1 and mem_ifetch=0, with ctl_ram_we=1 only for opcode 3; on mem_ack go to WB.
REQ-020 WB: SHALL pulse pc_we=1 and drive ctl_regs_we equal to the latched regs_we; next state is FETCH.
REQ-021 ctl_branch_taken SHALL be the registered taken bit during WB and 0 in all other states.
REQ-022 ctl_branch_ind SHALL equal latched opcode[1] when branch_op=1, else 0.
REQ-023 ctl_alu_pc, ctl_alu_imm, ctl_alu_altdest and ctl_wdata_ram SHALL follow the latched word in EXEC, MEM and WB, and be 0 in FETCH, DECODE and FAULT.
REQ-024 Wait counter: TMO_W bits, cleared on entry to FETCH and MEM, incremented each FETCH/MEM cycle without mem_ack, saturating.
REQ-025 Timeout: a cycle with count = 2^TMO_W-1 and no mem_ack SHALL go to FAULT; mem_ack on that same cycle SHALL win.
REQ-026 FAULT: SHALL drive all strobes and ctl_* outputs to 0 and fault=1, and SHALL stay there until reset.
REQ-027 Latency: ALU/branch/NOP instructions SHALL take 4 cycles plus fetch wait; LW/SW SHALL take 5 cycles plus both waits.

Reset
REQ-028 Reset SHALL asynchronously force state=FETCH, wait counter=0, control word=0, taken=0 and fault=0.
REQ-029 While reset is high, every output SHALL be 0 except state=0; mem_req SHALL rise on the first clk edge after reset deasserts.
REQ-030 Reset asserted mid-transfer SHALL abandon that transfer with no ir_we, pc_we or ctl_regs_we pulse.

Structure
REQ-031 A shared package SHALL hold the state encodings, the opcode constants, the 7-bit control-word field positions and the decode table function.
REQ-032 The combinational opcode-to-word table SHALL be one sub-module, control_decode, instantiated once and latched by control_mc.

Verification
REQ-033 Opcode 1 with mem_ack on the first FETCH cycle SHALL give states 0,1,2,4,0 and exactly one ctl_regs_we pulse in WB with ctl_alu_imm=1.
REQ-034 Opcode 3 with a 2-cycle MEM wait SHALL hold ctl_ram_we=1 for 3 MEM cycles, keep ctl_regs_we=0, and pulse pc_we once.
REQ-035 Opcodes 4 and 5 with ctl_adata_zero=1 SHALL give ctl_branch_taken=1 and =0 in WB respectively, with ctl_branch_ind=0; opcode 7 with adata_zero=0 SHALL give taken=1 and ind=1.
REQ-036 With TMO_W=4 and mem_ack held low in FETCH, the block SHALL enter FAULT after 15 cycles; mem_ack on cycle 15 SHALL instead go to DECODE.
REQ-037 Opcode 9 SHALL give FAULT when FAULT_ON_UNDEF=1, and a NOP-like pass with zero strobes except pc_we when FAULT_ON_UNDEF=0.
REQ-038 Reset pulsed during MEM of opcode 2 SHALL give state=0 immediately, no ctl_regs_we pulse, and a clean FETCH afterwards.

Source files
------------

// File: rtl/control_mc_pkg.sv
// Shared definitions for the multi-cycle control unit: state encodings, opcodes,
// control-word field positions and the opcode decode table.
package control_mc_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd7
  } state_e;

  localparam int unsigned CwW = 7;

  // Control word layout: {alu_pc, alu_imm, regs_we, ram_we, altdest, branch_op, wdata_ram}
  localparam int unsigned CwAluPc    = 6;
  localparam int unsigned CwAluImm   = 5;
  localparam int unsigned CwRegsWe   = 4;
  localparam int unsigned CwRamWe    = 3;
  localparam int unsigned CwAltdest  = 2;
  localparam int unsigned CwBranch   = 1;
  localparam int unsigned CwWdataRam = 0;

  localparam logic [3:0] OpAlu    = 4'd0;
  localparam logic [3:0] OpAluImm = 4'd1;
  localparam logic [3:0] OpLw     = 4'd2;
  localparam logic [3:0] OpSw     = 4'd3;
  localparam logic [3:0] OpBr4    = 4'd4;
  localparam logic [3:0] OpBr5    = 4'd5;
  localparam logic [3:0] OpBr6    = 4'd6;
  localparam logic [3:0] OpBr7    = 4'd7;
  localparam logic [3:0] OpNop    = 4'd14;

  // Returns {valid, word}; undefined opcodes yield valid=0 and an all-zero word.
  function automatic logic [CwW:0] decode_entry(input logic [3:0] op);
    logic [CwW:0] r;
    case (op)
      OpAlu:          r = {1'b1, 7'b0010000};
      OpAluImm:       r = {1'b1, 7'b0110100};
      OpLw:           r = {1'b1, 7'b0110101};
      OpSw:           r = {1'b1, 7'b0101000};
      OpBr4, OpBr5:   r = {1'b1, 7'b1010110};
      OpBr6, OpBr7:   r = {1'b1, 7'b1010010};
      OpNop:          r = {1'b1, 7'b1100000};
      default:        r = {1'b0, 7'b0000000};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-word table.
module control_decode
  import control_mc_pkg::*;
(
  input  logic [3:0]     opcode,
  output logic [CwW-1:0] word,
  output logic           valid
);

  always_comb begin
    {valid, word} = decode_entry(opcode);
  end

endmodule

// File: rtl/control_mc.sv
// Multi-cycle controller: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a memory
// wait timeout and a sticky FAULT state.
module control_mc
  import control_mc_pkg::*;
#(
  parameter int unsigned TMO_W          = 4,
  parameter bit          FAULT_ON_UNDEF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       ctl_adata_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_ifetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic       ctl_alu_pc,
  output logic       ctl_alu_imm,
  output logic       ctl_alu_altdest,
  output logic       ctl_wdata_ram,
  output logic       ctl_branch_ind,
  output logic       ctl_branch_taken,
  output logic       ctl_regs_we,
  output logic       ctl_ram_we,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [TMO_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [CwW-1:0]   word_q, word_d;
  logic [3:0]       opc_q, opc_d;
  logic             taken_q, taken_d;
  logic             fault_q, fault_d;
  logic             run_q;

  logic [CwW-1:0]   dec_word;
  logic             dec_valid;
  logic             in_xmw;

  control_decode u_decode (
    .opcode (opcode),
    .word   (dec_word),
    .valid  (dec_valid)
  );

  // run_q holds the FSM idle until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      word_q  <= '0;
      opc_q   <= '0;
      taken_q <= 1'b0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      opc_q   <= opc_d;
      taken_q <= taken_d;
      fault_q <= fault_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    opc_d   = opc_q;
    taken_d = taken_q;
    if (run_q) begin
      case (state_q)
        StFetch, StMem: begin
          if (mem_ack) begin
            state_d = (state_q == StFetch) ? StDecode : StWb;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StFault;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDecode: begin
          opc_d = opcode;
          if (!dec_valid && FAULT_ON_UNDEF) begin
            state_d = StFault;
          end else begin
            word_d  = dec_word;
            state_d = StExec;
          end
        end
        StExec: begin
          taken_d = word_q[CwBranch] & (ctl_adata_zero != opc_q[0]);
          state_d = (opc_q == OpLw || opc_q == OpSw) ? StMem : StWb;
          cnt_d   = '0;
        end
        StWb: begin
          state_d = StFetch;
          cnt_d   = '0;
        end
        StFault: state_d = StFault;
        default: state_d = StFault;
      endcase
    end
    fault_d = fault_q | (state_d == StFault);
  end

  always_comb begin
    in_xmw           = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);
    mem_req          = run_q && ((state_q == StFetch) || (state_q == StMem));
    mem_ifetch       = run_q && (state_q == StFetch);
    ir_we            = run_q && (state_q == StFetch) && mem_ack;
    pc_we            = (state_q == StWb);
    ctl_regs_we      = (state_q == StWb) && word_q[CwRegsWe];
    ctl_ram_we       = (state_q == StMem) && word_q[CwRamWe];
    ctl_branch_taken = (state_q == StWb) && taken_q;
    ctl_branch_ind   = in_xmw && word_q[CwBranch] && opc_q[1];
    ctl_alu_pc       = in_xmw && word_q[CwAluPc];
    ctl_alu_imm      = in_xmw && word_q[CwAluImm];
    ctl_alu_altdest  = in_xmw && word_q[CwAltdest];
    ctl_wdata_ram    = in_xmw && word_q[CwWdataRam];
    fault            = fault_q;
    state            = state_q;
  end

endmodule

// File: tb/tb_control_mc.sv
// Randomized scoreboard bench for control_mc: a driver plays instructions and
// queues the expected write-back controls; a monitor checks every WB cycle.
module tb_control_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       ctl_adata_zero = 1'b0;
  logic       mem_ack = 1'b0;

  logic mem_req, mem_ifetch, ir_we, pc_we, ctl_alu_pc, ctl_alu_imm, ctl_alu_altdest;
  logic ctl_wdata_ram, ctl_branch_ind, ctl_branch_taken, ctl_regs_we, ctl_ram_we, fault;
  logic [2:0] state;

  logic nf_mem_req, nf_mem_ifetch, nf_ir_we, nf_pc_we, nf_alu_pc, nf_alu_imm, nf_altdest;
  logic nf_wdata_ram, nf_branch_ind, nf_branch_taken, nf_regs_we, nf_ram_we, nf_fault;
  logic [2:0] nf_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [6:0] exp_q[$];

  control_mc #(.TMO_W(4), .FAULT_ON_UNDEF(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ctl_adata_zero(ctl_adata_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_ifetch(mem_ifetch), .ir_we(ir_we),
    .pc_we(pc_we), .ctl_alu_pc(ctl_alu_pc), .ctl_alu_imm(ctl_alu_imm),
    .ctl_alu_altdest(ctl_alu_altdest), .ctl_wdata_ram(ctl_wdata_ram),
    .ctl_branch_ind(ctl_branch_ind), .ctl_branch_taken(ctl_branch_taken),
    .ctl_regs_we(ctl_regs_we), .ctl_ram_we(ctl_ram_we), .fault(fault), .state(state)
  );

  control_mc #(.TMO_W(4), .FAULT_ON_UNDEF(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .opcode(opcode), .ctl_adata_zero(ctl_adata_zero),
    .mem_ack(mem_ack), .mem_req(nf_mem_req), .mem_ifetch(nf_mem_ifetch), .ir_we(nf_ir_we),
    .pc_we(nf_pc_we), .ctl_alu_pc(nf_alu_pc), .ctl_alu_imm(nf_alu_imm),
    .ctl_alu_altdest(nf_altdest), .ctl_wdata_ram(nf_wdata_ram),
    .ctl_branch_ind(nf_branch_ind), .ctl_branch_taken(nf_branch_taken),
    .ctl_regs_we(nf_regs_we), .ctl_ram_we(nf_ram_we), .fault(nf_fault), .state(nf_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected WB controls {regs_we, taken, ind, alu_pc, alu_imm, altdest, wdata_ram},
  // derived from each instruction's class.
  function automatic logic [6:0] model_wb(input logic [3:0] op, input logic az);
    bit is_alu, is_alui, is_lw, is_sw, is_br, is_nop, taken, ind;
    is_alu  = (op == 4'd0);
    is_alui = (op == 4'd1);
    is_lw   = (op == 4'd2);
    is_sw   = (op == 4'd3);
    is_br   = (op >= 4'd4) && (op <= 4'd7);
    is_nop  = (op == 4'd14);
    // Even branch opcodes branch on zero, odd ones on non-zero.
    taken   = is_br && (((op % 2) == 0) ? az : !az);
    ind     = is_br && (op == 4'd6 || op == 4'd7);
    return {is_alu | is_alui | is_lw | is_br,            // regs_we
            taken, ind,
            is_br | is_nop,                              // alu_pc
            is_alui | is_lw | is_sw | is_nop,            // alu_imm
            is_alui | is_lw | (op == 4'd4) | (op == 4'd5), // altdest
            is_lw};                                      // wdata_ram
  endfunction

  function automatic logic [12:0] all_out();
    return {mem_req, mem_ifetch, ir_we, pc_we, ctl_alu_pc, ctl_alu_imm, ctl_alu_altdest,
            ctl_wdata_ram, ctl_branch_ind, ctl_branch_taken, ctl_regs_we, ctl_ram_we, fault};
  endfunction

  // Monitor: every WB cycle must match the oldest queued instruction.
  always @(negedge clk) begin
    if (!reset) begin
      check("regs_we_outside_wb", {31'd0, ctl_regs_we & ~pc_we}, 32'd0);
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", 32'd1, 32'd0);
        end else begin
          check("wb_controls",
                {25'd0, ctl_regs_we, ctl_branch_taken, ctl_branch_ind, ctl_alu_pc,
                 ctl_alu_imm, ctl_alu_altdest, ctl_wdata_ram},
                {25'd0, exp_q.pop_front()});
          check("wb_ram_we", {31'd0, ctl_ram_we}, 32'd0);
        end
      end
    end
  end

  // Leaves the bench at a negedge in the first FETCH cycle after reset.
  task automatic finish_reset();
    @(negedge clk);
    check("reset_outputs", {19'd0, all_out()}, 32'd0);
    check("reset_state", {29'd0, state}, 32'd0);
    reset = 1'b0;
    #1 check("req_low_before_edge", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("req_after_edge", {29'd0, mem_req, mem_ifetch, ir_we}, 32'd6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b0;
    finish_reset();
  endtask

  task automatic run_instr(input logic [3:0] op, input logic az, input int fw, input int mw);
    int cyc;
    int ram_cnt;
    bit is_mem;
    is_mem = (op == 4'd2) || (op == 4'd3);
    exp_q.push_back(model_wb(op, az));
    opcode = op;
    ctl_adata_zero = az;
    cyc = 0;
    ram_cnt = 0;
    check("fetch", {27'd0, mem_req, mem_ifetch, state}, {27'd0, 2'b11, 3'd0});
    repeat (fw) begin
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b1;
    #1 check("ir_we", {31'd0, ir_we}, 32'd1);
    @(negedge clk);
    cyc++;
    mem_ack = 1'b0;
    check("decode", {29'd0, state}, 32'd1);
    @(negedge clk);
    cyc++;
    check("exec", {29'd0, state}, 32'd2);
    @(negedge clk);
    cyc++;
    if (is_mem) begin
      for (int i = 0; i <= mw; i++) begin
        check("mem", {27'd0, state, mem_req, mem_ifetch}, {27'd0, 3'd3, 2'b10});
        ram_cnt += int'(ctl_ram_we);
        if (i == mw) mem_ack = 1'b1;
        @(negedge clk);
        cyc++;
      end
      mem_ack = 1'b0;
      check("ram_we_cycles", ram_cnt, (op == 4'd3) ? mw + 1 : 0);
    end
    check("wb", {29'd0, state}, 32'd4);
    @(negedge clk);
    cyc++;
    check("latency", cyc, (is_mem ? 5 + mw : 4) + fw);
    check("next_fetch", {29'd0, state}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops[9];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd14};
    finish_reset();

    // Directed instructions
    run_instr(4'd1, 1'b0, 0, 0);
    run_instr(4'd3, 1'b0, 1, 2);
    run_instr(4'd4, 1'b1, 0, 0);
    run_instr(4'd5, 1'b1, 2, 0);
    run_instr(4'd7, 1'b0, 0, 0);
    run_instr(4'd6, 1'b0, 1, 0);
    run_instr(4'd14, 1'b1, 0, 0);
    run_instr(4'd0, 1'b0, 3, 0);
    run_instr(4'd2, 1'b1, 0, 3);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));

    // Fetch timeout: 15 waiting cycles then a cycle at the saturated count
    do_reset();
    repeat (15) @(negedge clk);
    check("tmo_not_yet", {29'd0, state}, 32'd0);
    @(negedge clk);
    check("tmo_fault_state", {29'd0, state}, 32'd7);
    check("tmo_outputs", {19'd0, all_out()}, 32'd1);
    repeat (3) @(negedge clk);
    check("fault_sticky", {28'd0, fault, state}, {28'd0, 1'b1, 3'd7});
    do_reset();
    run_instr(4'd1, 1'b0, 15, 0);

    // Undefined opcode: fault on one instance, NOP-like pass on the other
    do_reset();
    opcode = 4'd9;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("undef_fault", {28'd0, fault, state}, {28'd0, 1'b1, 3'd7});
    check("undef_fault_out", {19'd0, all_out()}, 32'd1);
    check("undef_nf_exec", {29'd0, nf_state}, 32'd2);
    @(negedge clk);
    check("undef_nf_wb", {29'd0, nf_state}, 32'd4);
    check("undef_nf_strobes",
          {22'd0, nf_pc_we, nf_regs_we, nf_ram_we, nf_branch_taken, nf_branch_ind,
           nf_alu_pc, nf_alu_imm, nf_altdest, nf_wdata_ram, nf_fault},
          {22'd0, 1'b1, 9'd0});
    @(negedge clk);
    check("undef_nf_fetch", {29'd0, nf_state}, 32'd0);
    do_reset();

    // Reset pulsed mid-MEM of a load abandons it
    opcode = 4'd2;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_mem", {29'd0, state}, 32'd3);
    #2 reset = 1'b1;
    #1 check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_outputs", {19'd0, all_out()}, 32'd0);
    finish_reset();
    run_instr(4'd2, 1'b0, 1, 1);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
